// File: rtl/alu_multicycle.sv
// Multi-cycle ADD/SUB/MUL/DIV unit with a start/done handshake toward the control unit.
// Optional AND/XOR opcodes (110/111) are built only when ALU_LOGIC_OPS_EN is defined.
module alu_multicycle #(
  parameter int WIDTH      = 16,
  parameter int ITER_CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_start,
  input  logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_result_low,
  output logic [WIDTH-1:0] alu_result_high,
  output logic             alu_done,
  output logic             alu_busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
`ifdef ALU_LOGIC_OPS_EN
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;
`endif

  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ITER,
    S_FINISH,
    S_RELEASE
  } state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              op_reg, op_next;
  logic [WIDTH-1:0]        a_reg, a_next;
  logic [WIDTH-1:0]        b_reg, b_next;
  logic [2*WIDTH-1:0]      acc_reg, acc_next;
  logic [ITER_CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]        low_reg, low_next;
  logic [WIDTH-1:0]        high_reg, high_next;
  logic                    done_reg, done_next;
  logic                    busy_reg, busy_next;

  logic                    iter_op;
  logic [WIDTH:0]          add_sum;
  logic [WIDTH:0]          sub_diff;
  logic [WIDTH:0]          mul_sum;
  logic [WIDTH:0]          div_shift;
  logic                    div_borrow;
  logic [WIDTH-1:0]        div_rem;

  // Division by zero is resolved in a single cycle, so it never enters ITER.
  assign iter_op = (alu_opcode == OP_MUL) ||
                   ((alu_opcode == OP_DIV) && (alu_b != '0));

  assign add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign sub_diff = {1'b0, a_reg} - {1'b0, b_reg};

  // Shift-add multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                   {1'b0, (acc_reg[0] ? a_reg : {WIDTH{1'b0}})};

  // Restoring divide: acc holds {remainder, dividend bits / quotient bits}.
  assign div_shift  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_borrow = (div_shift < {1'b0, b_reg});
  assign div_rem    = div_borrow ? div_shift[WIDTH-1:0] : (div_shift[WIDTH-1:0] - b_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (alu_start) state_next = iter_op ? S_ITER : S_CALC;
      S_CALC:    state_next = S_RELEASE;
      S_ITER:    if (cnt_reg == LAST_ITER) state_next = S_FINISH;
      S_FINISH:  state_next = S_RELEASE;
      S_RELEASE: if (!alu_start) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    op_next   = op_reg;
    a_next    = a_reg;
    b_next    = b_reg;
    acc_next  = acc_reg;
    cnt_next  = cnt_reg;
    low_next  = low_reg;
    high_next = high_reg;
    done_next = 1'b0;
    busy_next = busy_reg;
    case (state_reg)
      S_IDLE: begin
        if (alu_start) begin
          op_next   = alu_opcode;
          a_next    = alu_a;
          b_next    = alu_b;
          cnt_next  = '0;
          busy_next = 1'b1;
          acc_next  = (alu_opcode == OP_MUL) ? {{WIDTH{1'b0}}, alu_b}
                                             : {{WIDTH{1'b0}}, alu_a};
        end
      end
      S_CALC: begin
        done_next = 1'b1;
        case (op_reg)
          OP_ADD: begin
            low_next  = add_sum[WIDTH-1:0];
            high_next = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
          end
          OP_SUB: begin
            low_next  = sub_diff[WIDTH-1:0];
            high_next = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
          end
          OP_DIV: begin
            low_next  = {WIDTH{1'b1}};
            high_next = a_reg;
          end
`ifdef ALU_LOGIC_OPS_EN
          OP_AND: begin
            low_next  = a_reg & b_reg;
            high_next = '0;
          end
          OP_XOR: begin
            low_next  = a_reg ^ b_reg;
            high_next = '0;
          end
`endif
          default: begin
            low_next  = '0;
            high_next = '0;
          end
        endcase
      end
      S_ITER: begin
        if (op_reg == OP_MUL) begin
          acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end else begin
          acc_next = {div_rem, acc_reg[WIDTH-2:0], ~div_borrow};
        end
        if (cnt_reg != LAST_ITER) cnt_next = cnt_reg + 1'b1;
      end
      S_FINISH: begin
        done_next = 1'b1;
        low_next  = acc_reg[WIDTH-1:0];
        high_next = acc_reg[2*WIDTH-1:WIDTH];
      end
      S_RELEASE: begin
        busy_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      low_reg  <= '0;
      high_reg <= '0;
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      op_reg   <= op_next;
      a_reg    <= a_next;
      b_reg    <= b_next;
      acc_reg  <= acc_next;
      cnt_reg  <= cnt_next;
      low_reg  <= low_next;
      high_reg <= high_next;
      done_reg <= done_next;
      busy_reg <= busy_next;
    end
  end

  assign alu_result_low  = low_reg;
  assign alu_result_high = high_reg;
  assign alu_done        = done_reg;
  assign alu_busy        = busy_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, start/reset corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_start;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result_low;
  logic [15:0] alu_result_high;
  logic        alu_done;
  logic        alu_busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_low  = 16'h0;
  logic [15:0] prev_high = 16'h0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_low;
    logic [15:0] exp_high;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  alu_multicycle dut (
    .clk             (clk),
    .reset           (reset),
    .alu_start       (alu_start),
    .alu_opcode      (alu_opcode),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_result_low  (alu_result_low),
    .alu_result_high (alu_result_high),
    .alu_done        (alu_done),
    .alu_busy        (alu_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions of each opcode.
  task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] lo, output logic [15:0] hi, output int lat);
    int unsigned ua, ub;
    ua = a;
    ub = b;
    lo = 16'h0;
    hi = 16'h0;
    lat = 1;
    case (op)
      3'd0: begin lo = 16'((ua + ub) % 65536); hi = 16'((ua + ub) / 65536); end
      3'd1: begin lo = 16'((ua + 65536 - ub) % 65536); hi = (ua < ub) ? 16'h1 : 16'h0; end
      3'd2: begin lo = 16'((ua * ub) % 65536); hi = 16'((ua * ub) / 65536); lat = 17; end
      3'd3: begin
        if (ub == 0) begin lo = 16'hFFFF; hi = a; end
        else begin lo = 16'(ua / ub); hi = 16'(ua % ub); lat = 17; end
      end
`ifdef ALU_LOGIC_OPS_EN
      3'd6: lo = a & b;
      3'd7: lo = a ^ b;
`endif
      default: ;
    endcase
  endtask

  // Issues one request, scrambles the operand inputs after accept, and checks the handshake.
  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_lo,
                        input logic [15:0] exp_hi, input int exp_lat);
    int lat;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    alu_opcode = op;
    alu_a = a;
    alu_b = b;
    alu_start = 1'b1;
    @(posedge clk); #1;
    check({name, " busy_after_accept"}, {31'h0, alu_busy}, 32'h1);
    check({name, " results_kept_at_accept"}, {alu_result_high, alu_result_low}, {prev_high, prev_low});
    alu_opcode = 3'($urandom);
    alu_a = 16'($urandom);
    alu_b = 16'($urandom);
    lat = 0;
    seen = 0;
    busy_ok = 1;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!alu_busy) busy_ok = 0;
      if (alu_done) seen = 1;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy_through_done"}, {31'h0, busy_ok}, 32'h1);
    check({name, " result"}, {alu_result_high, alu_result_low}, {exp_hi, exp_lo});
    alu_start = 1'b0;
    @(posedge clk); #1;
    check({name, " done_width"}, {30'h0, alu_done, alu_busy}, 32'h0);
    check({name, " result_hold"}, {alu_result_high, alu_result_low}, {exp_hi, exp_lo});
    prev_low = exp_lo;
    prev_high = exp_hi;
    $display("%s: op=%0d a=%h b=%h -> low=%h high=%h latency=%0d", name, op, a, b,
             alu_result_low, alu_result_high, lat);
  endtask

  initial begin
    vecs[0]  = '{"add_carry",  3'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1};
    vecs[1]  = '{"sub_borrow", 3'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0001, 1};
    vecs[2]  = '{"mul_shift",  3'd2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 17};
    vecs[3]  = '{"div_100_7",  3'd3, 16'd100,  16'd7,    16'd14,   16'd2,    17};
    vecs[4]  = '{"div_zero",   3'd3, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1};
    vecs[5]  = '{"op_load",    3'd4, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 1};
    vecs[6]  = '{"op_store",   3'd5, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1};
    vecs[7]  = '{"mul_max",    3'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 17};
    vecs[8]  = '{"div_by_one", 3'd3, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 17};
    vecs[9]  = '{"div_small",  3'd3, 16'd5,    16'd9,    16'h0000, 16'd5,    17};
    vecs[10] = '{"sub_equal",  3'd1, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1};
`ifdef ALU_LOGIC_OPS_EN
    vecs[11] = '{"op_and",     3'd6, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 1};
    vecs[12] = '{"op_xor",     3'd7, 16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 1};
`else
    vecs[11] = '{"op_rsvd6",   3'd6, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 1};
    vecs[12] = '{"op_rsvd7",   3'd7, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 1};
`endif

    reset = 1'b0;
    alu_start = 1'b0;
    alu_opcode = 3'd0;
    alu_a = 16'h0;
    alu_b = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {alu_result_high, alu_result_low}, 32'h0);
    check("reset_flags", {30'h0, alu_done, alu_busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_low, vecs[i].exp_high, vecs[i].exp_lat);
    end

    // Start held high past done must not retrigger.
    @(negedge clk);
    alu_opcode = 3'd0;
    alu_a = 16'h0001;
    alu_b = 16'h0001;
    alu_start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_first_done", {15'h0, alu_done, alu_result_low}, {15'h0, 1'b1, 16'h0002});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_no_reaccept", {30'h0, alu_done, alu_busy}, 32'h0);
    end
    alu_start = 1'b0;
    @(posedge clk); #1;
    prev_low = 16'h0002;
    prev_high = 16'h0000;
    run_op("after_hold", 3'd0, 16'd4, 16'd5, 16'd9, 16'd0, 1);

    // Reset in the middle of a multiply, with start held through reset.
    @(negedge clk);
    alu_opcode = 3'd2;
    alu_a = 16'h1234;
    alu_b = 16'h0100;
    alu_start = 1'b1;
    @(posedge clk); #1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_mul_busy", {31'h0, alu_busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("async_reset_results", {alu_result_high, alu_result_low}, 32'h0);
    check("async_reset_flags", {30'h0, alu_done, alu_busy}, 32'h0);
    alu_opcode = 3'd0;
    alu_a = 16'd2;
    alu_b = 16'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset_beats_start", {30'h0, alu_done, alu_busy}, 32'h0);
    alu_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    prev_low = 16'h0;
    prev_high = 16'h0;
    run_op("add_after_reset", 3'd0, 16'd2, 16'd3, 16'd5, 16'd0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [15:0] a, b, lo, hi;
      int          lat;
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = (($urandom % 4) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      model(op, a, b, lo, hi, lat);
      run_op("random", op, a, b, lo, hi, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
